memory_bank: RTL

MEMORY_BANK -- requirements
Module: memory_bank

---
 rtl/memory_bank.sv | 53 +++++
 1 files changed

// File: rtl/memory_bank.sv
// memory_bank: single-port register-file memory with a registered read port.
// Reads are write-first when a read and a write target the same word in the
// same cycle. Reset clears every word and the read outputs asynchronously.
module memory_bank #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              w,
    input  logic              r,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  DIn,
    output logic [WIDTH-1:0]  DOut,
    output logic              valid
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;
    logic             rd_en;

    // Chip select gates both requests; an X on w or r with cs low resolves to 0.
    assign wr_en = cs & w;
    assign rd_en = cs & r;

    // Storage array: cleared by reset, otherwise updated at the addressed word only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[addr] <= DIn;
        end
    end

    // Read port: DOut captures the word (or the incoming write data on a same-cycle write) and holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            DOut  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= rd_en;
            if (rd_en) begin
                DOut <= wr_en ? DIn : mem[addr];
            end
        end
    end

endmodule
